// File: rtl/brp_gshare.sv
// Direction predictor: table of saturating counters indexed by PC or PC^GHR.
// Post-reset sweep clears the table; accuracy statistics saturate.
module brp_gshare #(
  parameter int IDX_BITS = 7,
  parameter int CTR_W    = 2,
  parameter int GHR_LEN  = 7,
  parameter int MODE     = 1,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_valid,
  input  logic [31:0]         lookup_pc,
  output logic                pred_taken,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_pred,
  input  logic                upd_taken,
  output logic                ready,
  output logic [GHR_LEN-1:0]  ghr,
  output logic [CNT_W-1:0]    stat_total,
  output logic [CNT_W-1:0]    stat_correct
);

  localparam int N = 2 ** IDX_BITS;
  localparam logic [CTR_W-1:0] WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(N - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t state_q, state_d;
  logic [IDX_BITS-1:0] ptr_q, ptr_d;
  logic [CTR_W-1:0] tbl [N];
  logic [GHR_LEN-1:0] ghr_q;
  logic [GHR_LEN:0] ghr_sh;
  logic [CNT_W-1:0] tot_q, cor_q;
  logic [IDX_BITS-1:0] base, hist;
  logic [CTR_W-1:0] ctr_cur;
  logic upd_en;
  logic unused_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready   = 1'b0;
    unique case (state_q)
      INIT: begin
        ptr_d = ptr_q + IDX_BITS'(1);
        if (ptr_q == LAST) state_d = RUN;
      end
      RUN: ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  assign upd_en  = upd_valid & ready;
  assign ctr_cur = tbl[upd_idx];

  // Table has no reset; the INIT sweep owns clearing it.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      tbl[ptr_q] <= WNT;
    end else if (upd_en) begin
      if (upd_taken && ctr_cur != '1)
        tbl[upd_idx] <= ctr_cur + CTR_W'(1);
      else if (!upd_taken && ctr_cur != '0)
        tbl[upd_idx] <= ctr_cur - CTR_W'(1);
    end
  end

  assign ghr_sh = {ghr_q, upd_taken};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
      tot_q <= '0;
      cor_q <= '0;
    end else if (upd_en) begin
      ghr_q <= ghr_sh[GHR_LEN-1:0];
      if (tot_q != '1) tot_q <= tot_q + CNT_W'(1);
      if (upd_pred == upd_taken && cor_q != '1)
        cor_q <= cor_q + CNT_W'(1);
    end
  end

  always_comb begin
    hist = '0;
    hist[GHR_LEN-1:0] = ghr_q;
  end

  assign base      = lookup_pc[IDX_BITS+1:2];
  assign pred_idx  = (MODE == 0) ? base : (base ^ hist);
  assign pred_taken = ready & lookup_valid & tbl[pred_idx][CTR_W-1];
  assign unused_pc = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0]};

  assign ghr          = ghr_q;
  assign stat_total   = tot_q;
  assign stat_correct = cor_q;

endmodule

// File: tb/tb_brp_gshare.sv
// Bench for brp_gshare: gshare and bimodal instances vs a behavioural model.
// Shared stimulus, randomized plus directed sequences.
module tb_brp_gshare;

  logic clk = 1'b0;
  logic rst;
  logic lookup_valid;
  logic [31:0] lookup_pc;
  logic upd_valid;
  logic [6:0] upd_idx;
  logic upd_pred, upd_taken;

  logic pt_a, pt_b, rdy_a, rdy_b;
  logic [6:0] pi_a, pi_b, ghr_a;
  logic ghr_b;
  logic [31:0] tot_a, cor_a;
  logic [3:0] tot_b, cor_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  brp_gshare #(
    .IDX_BITS(7), .CTR_W(2), .GHR_LEN(7), .MODE(1), .CNT_W(32)
  ) u_gs (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_taken(pt_a), .pred_idx(pi_a),
    .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_pred(upd_pred), .upd_taken(upd_taken),
    .ready(rdy_a), .ghr(ghr_a),
    .stat_total(tot_a), .stat_correct(cor_a)
  );

  brp_gshare #(
    .IDX_BITS(7), .CTR_W(2), .GHR_LEN(1), .MODE(0), .CNT_W(4)
  ) u_bm (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_taken(pt_b), .pred_idx(pi_b),
    .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_pred(upd_pred), .upd_taken(upd_taken),
    .ready(rdy_b), .ghr(ghr_b),
    .stat_total(tot_b), .stat_correct(cor_b)
  );

  // Reference model: k=0 gshare (7-bit history, 32-bit stats),
  // k=1 bimodal (1-bit history, 4-bit stats). Both 2-bit counters.
  int m_tbl [2][128];
  int m_ghr [2];
  longint m_tot [2];
  longint m_cor [2];
  bit m_rdy [2];
  int m_sw [2];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      m_rdy[k] = 1'b0;
      m_sw[k]  = 0;
      m_ghr[k] = 0;
      m_tot[k] = 0;
      m_cor[k] = 0;
    end
  endfunction

  function automatic int m_idx(int k, logic [31:0] pc);
    int b;
    b = int'((pc >> 2) & 32'h7f);
    return (k == 0) ? (b ^ m_ghr[0]) : b;
  endfunction

  function automatic bit m_pred(int k);
    return m_rdy[k] && lookup_valid &&
           (m_tbl[k][m_idx(k, lookup_pc)] >= 2);
  endfunction

  function automatic void m_step(int k);
    int c;
    longint cmax;
    int gmask;
    cmax  = (k == 0) ? 64'hffff_ffff : 64'd15;
    gmask = (k == 0) ? 127 : 1;
    if (!m_rdy[k]) begin
      m_sw[k]++;
      if (m_sw[k] == 128) begin
        m_rdy[k] = 1'b1;
        for (int i = 0; i < 128; i++) m_tbl[k][i] = 1;
      end
    end else if (upd_valid) begin
      c = m_tbl[k][upd_idx];
      if (upd_taken) c = (c < 3) ? c + 1 : 3;
      else c = (c > 0) ? c - 1 : 0;
      m_tbl[k][upd_idx] = c;
      m_ghr[k] = ((m_ghr[k] << 1) | int'(upd_taken)) & gmask;
      if (m_tot[k] < cmax) m_tot[k]++;
      if (upd_pred == upd_taken && m_cor[k] < cmax) m_cor[k]++;
    end
  endfunction

  task automatic drive(input logic lv, input logic [31:0] pc,
                       input logic uv, input logic [6:0] ui,
                       input logic up, input logic ut);
    lookup_valid = lv;
    lookup_pc    = pc;
    upd_valid    = uv;
    upd_idx      = ui;
    upd_pred     = up;
    upd_taken    = ut;
    #1;
    chk("rdy_a", rdy_a, m_rdy[0]);
    chk("rdy_b", rdy_b, m_rdy[1]);
    chk("pred_a", pt_a, m_pred(0));
    chk("pred_b", pt_b, m_pred(1));
    chk("idx_a", pi_a, m_idx(0, pc));
    chk("idx_b", pi_b, m_idx(1, pc));
    chk("ghr_a", ghr_a, m_ghr[0]);
    chk("ghr_b", ghr_b, m_ghr[1]);
    chk("tot_a", tot_a, m_tot[0]);
    chk("cor_a", cor_a, m_cor[0]);
    chk("tot_b", tot_b, m_tot[1]);
    chk("cor_b", cor_b, m_cor[1]);
  endtask

  task automatic tick();
    m_step(0);
    m_step(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_drive();
    drive(1'($urandom), $urandom, 1'($urandom), 7'($urandom_range(0, 15)),
          1'($urandom), 1'($urandom));
  endtask

  // Runs until the model says ready (bounded); returns not-ready cycles.
  task automatic run_init(input bit force_upd, output int zero_cyc);
    zero_cyc = 0;
    for (int n = 0; n < 200 && !m_rdy[0]; n++) begin
      drive(1'b1, $urandom, force_upd ? 1'b1 : 1'($urandom),
            7'($urandom), 1'($urandom), 1'($urandom));
      if (rdy_a == 1'b0) zero_cyc++;
      tick();
    end
    #1;
    chk("ready_up", rdy_a, 1);
  endtask

  task automatic do_reset();
    lookup_valid = 1'b1;
    lookup_pc    = 32'h14;
    upd_valid    = 1'b0;
    rst = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_pred", pt_a, 0);
    chk("rst_ready", rdy_a, 0);
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int zc;
    bit exp_seq [7];
    logic t;
    exp_seq = '{0, 1, 1, 1, 1, 0, 0};

    do_reset();
    run_init(1'b0, zc);
    chk("init_len", zc, 128);
    chk("init_drop", tot_a, 0);
    for (int i = 0; i < 128; i++) begin
      drive(1'b1, 32'(i * 4), 1'b0, 7'd0, 1'b0, 1'b0);
      chk("wnt", pt_b, 0);
      tick();
    end

    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h14, i < 6, 7'd5, 1'b0, i < 3);
      chk("ctr5", pt_b, exp_seq[i]);
      tick();
    end

    do_reset();
    run_init(1'b0, zc);
    for (int i = 0; i < 20; i++) begin
      t = 1'($urandom);
      drive(1'b0, 32'h0, 1'b1, 7'($urandom),
            (i < 7 || i >= 10) ? t : ~t, t);
      tick();
      if (i == 9) begin
        #1;
        chk("st_tot10", tot_a, 10);
        chk("st_cor7", cor_a, 7);
        chk("st_totb10", tot_b, 10);
      end
    end
    #1;
    chk("st_sat_tot", tot_b, 15);
    chk("st_sat_cor", cor_b, 15);
    chk("st_tot20", tot_a, 20);
    chk("st_cor17", cor_a, 17);

    do_reset();
    run_init(1'b0, zc);
    drive(1'b0, 32'h0, 1'b1, 7'h20, 1'b1, 1'b1); tick();
    drive(1'b0, 32'h0, 1'b1, 7'h20, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b1, 7'h20, 1'b1, 1'b1); tick();
    drive(1'b1, 32'h40, 1'b0, 7'h0, 1'b0, 1'b0);
    chk("ghr_pat", ghr_a, 7'b0000101);
    chk("gs_idx", pi_a, 7'h15);
    chk("ghr1", ghr_b, 1);
    chk("bm_idx", pi_b, 7'h10);
    tick();

    drive(1'b1, 32'hC, 1'b1, 7'd3, 1'b0, 1'b1);
    chk("same_cyc", pt_b, 0);
    tick();
    drive(1'b1, 32'hC, 1'b0, 7'd3, 1'b0, 1'b0);
    chk("after_upd", pt_b, 1);
    tick();

    for (int i = 0; i < 600; i++) begin
      rand_drive();
      tick();
    end

    drive(1'b0, 32'h0, 1'b1, 7'd1, 1'b1, 1'b1);
    tick();
    upd_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("ar_ready", rdy_a, 0);
    chk("ar_ghr", ghr_a, 0);
    chk("ar_tot", tot_a, 0);
    chk("ar_cor", cor_a, 0);
    chk("ar_totb", tot_b, 0);
    rst = 1'b0;
    m_step(0);
    m_step(1);
    @(negedge clk);
    run_init(1'b1, zc);
    chk("ar_drop", tot_a, 0);
    chk("ar_len", zc, 127);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
